kb_host_ctrl: RTL

Parametrised PS/2 keyboard host controller that sits between the PS/2 transceiver and the UART transmitter. Every received scan-code byte is buffered in a FIFO and drained over a valid/ready handshake. The block tracks Caps/Num/Scroll lock state from make/break codes and drives the keyboard LEDs with the ED/flags command pair. The LED sequence includes ACK checking, timeout, resend handling and bounded retries.

---
 rtl/kb_host_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/kb_host_ctrl.sv
// kb_host_ctrl: PS/2 keyboard host with scan-code FIFO, lock-key tracking and LED command sequencing
module kb_host_ctrl #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DELAY_CYCLES = 255,
  parameter int ACK_TIMEOUT  = 100000,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_done_tick,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] led_status,
  output logic       led_error,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);
  typedef enum logic [3:0] {
    IDLE, DELAY, SEND_CMD, WAIT_TX_CMD, WAIT_ACK_CMD,
    SEND_FLAGS, WAIT_TX_FLAGS, WAIT_ACK_FLAGS, RETRY
  } state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0] retries;
  logic [7:0] tx_q;
  logic [2:0] toggle;
  logic pending, brk, ext, in_wait, is_ack, is_nak, push, push_ok, pop, empty, full, exhausted;
  assign in_wait   = state == WAIT_ACK_CMD || state == WAIT_ACK_FLAGS;
  assign is_ack    = rx_done_tick && rx_data == 8'hFA;
  assign is_nak    = rx_done_tick && rx_data == 8'hFE;
  assign push      = rx_done_tick && !(in_wait && (is_ack || is_nak));
  assign empty     = wr_ptr == rd_ptr;
  assign full      = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign exhausted = retries >= MAX_R;
  assign toggle    = (push && !brk && !ext) ? (rx_data == 8'h58 ? 3'b100 :
                     rx_data == 8'h77 ? 3'b010 : rx_data == 8'h7E ? 3'b001 : 3'b000) : 3'b000;
  // LED sequencer state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // LED sequencer transitions and transmit strobes; tx_data holds the last byte sent
  always_comb begin
    state_nxt = state;
    tx_write  = 1'b0;
    tx_data   = tx_q;
    case (state)
      IDLE:           state_nxt = pending ? DELAY : IDLE;
      DELAY:          state_nxt = cnt == '0 ? SEND_CMD : DELAY;
      SEND_CMD:       begin tx_write = 1'b1; tx_data = 8'hED; state_nxt = WAIT_TX_CMD; end
      WAIT_TX_CMD:    state_nxt = tx_done_tick ? WAIT_ACK_CMD : WAIT_TX_CMD;
      WAIT_ACK_CMD:   state_nxt = is_ack ? SEND_FLAGS : (is_nak || cnt == '0) ? RETRY : WAIT_ACK_CMD;
      SEND_FLAGS:     begin tx_write = 1'b1; tx_data = {5'b0, led_status}; state_nxt = WAIT_TX_FLAGS; end
      WAIT_TX_FLAGS:  state_nxt = tx_done_tick ? WAIT_ACK_FLAGS : WAIT_TX_FLAGS;
      WAIT_ACK_FLAGS: state_nxt = is_ack ? IDLE : (is_nak || cnt == '0) ? RETRY : WAIT_ACK_FLAGS;
      RETRY:          state_nxt = exhausted ? IDLE : SEND_CMD;
      default:        state_nxt = IDLE;
    endcase
  end
  // Shared delay/timeout down-counter and retry count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt     <= '0;
      retries <= '0;
    end else begin
      if (state == IDLE && pending) begin
        cnt     <= CNT_W'(DELAY_CYCLES - 1);
        retries <= '0;
      end else if ((state == WAIT_TX_CMD || state == WAIT_TX_FLAGS) && tx_done_tick)
        cnt <= CNT_W'(ACK_TIMEOUT - 1);
      else if ((state == DELAY || in_wait) && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (state == RETRY && !exhausted) retries <= retries + RW'(1);
    end
  // Lock parser, pending request, error/overflow flags, FIFO pointers and tx_data hold
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_q       <= '0;
      led_status <= '0;
      pending    <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      led_error  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      tx_q <= tx_data;
      if (toggle != 3'b000) begin
        led_status <= led_status ^ toggle;
        pending    <= 1'b1;
      end else if (state == IDLE) pending <= 1'b0;
      if (push) begin
        brk <= rx_data == 8'hF0 ? 1'b1 : rx_data == 8'hE0 ? brk : 1'b0;
        ext <= rx_data == 8'hE0 ? 1'b1 : rx_data == 8'hF0 ? ext : 1'b0;
      end
      if (state == RETRY && exhausted) led_error <= 1'b1;
      else if (state == WAIT_ACK_FLAGS && is_ack) led_error <= 1'b0;
      if (push && !push_ok) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  // FIFO storage
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_data;
endmodule
